// File: rtl/matrix_pkg.sv
// matrix_pkg: shared definitions for the matrix operation units.
//   ELEM_W / MAX_N / MAT_W : element width, maximum dimension, packed 5x5 image width
//   mat_size_t             : 2-bit matrix size encoding (00=2x2 .. 11=5x5)
//   ctrl_state_t           : sequencer state encoding
//   size_to_n()            : size code to dimension n
//   slot_idx()             : row-major slot index row*MAX_N+col inside the 5x5 image
package matrix_pkg;

    localparam int ELEM_W = 8;
    localparam int MAX_N  = 5;
    localparam int MAT_W  = MAX_N * MAX_N * ELEM_W;

    typedef enum logic [1:0] {
        SZ_2X2 = 2'b00,
        SZ_3X3 = 2'b01,
        SZ_4X4 = 2'b10,
        SZ_5X5 = 2'b11
    } mat_size_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } ctrl_state_t;

    function automatic logic [2:0] size_to_n(input mat_size_t sz);
        logic [2:0] n;
        case (sz)
            SZ_2X2:  n = 3'd2;
            SZ_3X3:  n = 3'd3;
            SZ_4X4:  n = 3'd4;
            SZ_5X5:  n = 3'd5;
            default: n = 3'd2;
        endcase
        return n;
    endfunction

    // Largest value is 4*5+4 = 24, so 5 bits always suffice.
    function automatic logic [4:0] slot_idx(input logic [2:0] row, input logic [2:0] col);
        return ({2'b00, row} * 5'd5) + {2'b00, col};
    endfunction

endpackage

// File: rtl/transposicao_matriz.sv
// transposicao_matriz: combinational transpose of a zero-padded 5x5 element image.
//   matrix_A       in  MAT_W  source image, slot (r,c) at bits (r*5+c)*ELEM_W
//   matrix_size    in  2      size code; slots outside the n x n corner read as 0
//   m_transposta_A out MAT_W  transposed image, slot (r,c) = source slot (c,r)
module transposicao_matriz
    import matrix_pkg::*;
(
    input  logic [MAT_W-1:0] matrix_A,
    input  logic [1:0]       matrix_size,
    output logic [MAT_W-1:0] m_transposta_A
);

    logic [2:0] w_n;

    assign w_n = size_to_n(mat_size_t'(matrix_size));

    // Swap row and column of every slot inside the active n x n corner.
    always_comb begin
        m_transposta_A = '0;
        for (int r = 0; r < MAX_N; r++) begin
            for (int c = 0; c < MAX_N; c++) begin
                if ((3'(r) < w_n) && (3'(c) < w_n)) begin
                    m_transposta_A[(r*MAX_N+c)*ELEM_W +: ELEM_W] = matrix_A[(c*MAX_N+r)*ELEM_W +: ELEM_W];
                end else begin
                    m_transposta_A[(r*MAX_N+c)*ELEM_W +: ELEM_W] = '0;
                end
            end
        end
    end

endmodule

// File: rtl/matrix_transpose_ctrl.sv
// matrix_transpose_ctrl: loads an n x n matrix (n=2..5) element by element,
// transposes it through transposicao_matriz and streams the result back out.
//   clk, rst_n               clock, asynchronous active-low reset
//   start, abort             begin an operation (IDLE only) / return to IDLE
//   matrix_size              size code, latched on an accepted start
//   in_data/in_valid/in_ready   row-major input stream
//   out_data/out_valid/out_ready row-major transposed output stream
//   busy, done               not-IDLE flag, one-cycle completion pulse
module matrix_transpose_ctrl
    import matrix_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        matrix_size,
    input  logic [ELEM_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ELEM_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    ctrl_state_t      r_state;
    logic [2:0]       r_row;
    logic [2:0]       r_col;
    mat_size_t        r_size;
    logic [MAT_W-1:0] r_src;
    logic [MAT_W-1:0] r_res;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;
    logic             r_done;

    ctrl_state_t      w_next_state;
    logic [2:0]       w_next_row;
    logic [2:0]       w_next_col;
    logic [2:0]       w_n;
    logic             w_last_col;
    logic             w_last;
    logic [4:0]       w_slot;
    logic [MAT_W-1:0] w_trans;

    assign w_n        = size_to_n(r_size);
    assign w_last_col = (r_col == (w_n - 3'd1));
    assign w_last     = w_last_col && (r_row == (w_n - 3'd1));
    assign w_slot     = slot_idx(r_row, r_col);

    transposicao_matriz u_transpose (
        .matrix_A       (r_src),
        .matrix_size    (r_size),
        .m_transposta_A (w_trans)
    );

    // Next state and row/col counters; abort outranks start and handshakes.
    always_comb begin
        w_next_state = r_state;
        w_next_row   = r_row;
        w_next_col   = r_col;
        if (abort) begin
            w_next_state = ST_IDLE;
            w_next_row   = 3'd0;
            w_next_col   = 3'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_next_state = ST_LOAD;
                        w_next_row   = 3'd0;
                        w_next_col   = 3'd0;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
                ST_LOAD, ST_DRAIN: begin
                    if ((r_state == ST_LOAD) ? in_valid : out_ready) begin
                        // The final transfer wraps both counters to 0 so they never reach n.
                        if (w_last) begin
                            w_next_state = (r_state == ST_LOAD) ? ST_COMPUTE : ST_DONE;
                            w_next_row   = 3'd0;
                            w_next_col   = 3'd0;
                        end else if (w_last_col) begin
                            w_next_row   = r_row + 3'd1;
                            w_next_col   = 3'd0;
                        end else begin
                            w_next_col   = r_col + 3'd1;
                        end
                    end else begin
                        w_next_state = r_state;
                    end
                end
                ST_COMPUTE: begin
                    w_next_state = ST_DRAIN;
                    w_next_row   = 3'd0;
                    w_next_col   = 3'd0;
                end
                ST_DONE: begin
                    w_next_state = ST_IDLE;
                end
                default: begin
                    w_next_state = ST_IDLE;
                    w_next_row   = 3'd0;
                    w_next_col   = 3'd0;
                end
            endcase
        end
    end

    // FSM state, counters, latched size and status outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_row       <= 3'd0;
            r_col       <= 3'd0;
            r_size      <= SZ_2X2;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_row   <= w_next_row;
            r_col   <= w_next_col;
            if (!abort && (r_state == ST_IDLE) && start) begin
                r_size <= mat_size_t'(matrix_size);
            end else begin
                r_size <= r_size;
            end
            r_in_ready  <= (w_next_state == ST_LOAD);
            r_out_valid <= (w_next_state == ST_DRAIN);
            r_busy      <= (w_next_state != ST_IDLE);
            r_done      <= (w_next_state == ST_DONE);
        end
    end

    // Source image fill and result capture; abort blocks the write but keeps contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src <= '0;
            r_res <= '0;
        end else begin
            if (!abort && (r_state == ST_IDLE) && start) begin
                r_src <= '0;
            end else if (!abort && (r_state == ST_LOAD) && in_valid) begin
                r_src[int'(w_slot)*ELEM_W +: ELEM_W] <= in_data;
            end else begin
                r_src <= r_src;
            end
            if (!abort && (r_state == ST_COMPUTE)) begin
                r_res <= w_trans;
            end else begin
                r_res <= r_res;
            end
        end
    end

    // Output element selected by the drain counters, forced to 0 when not valid.
    always_comb begin
        if (r_out_valid) begin
            out_data = r_res[int'(w_slot)*ELEM_W +: ELEM_W];
        end else begin
            out_data = '0;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_matrix_transpose_ctrl.sv
// Directed bench for matrix_transpose_ctrl. Expected output elements are pushed to a
// scoreboard queue when a matrix is loaded and popped by a monitor on each output
// handshake. "Cycle t0+k" below is the clock cycle that ends at the k-th rising edge
// after the edge that sampled start.
module tb_matrix_transpose_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] matrix_size = 2'b00;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       busy;
    logic       done;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         done_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mat_in[25];
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    matrix_transpose_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .matrix_size (matrix_size),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: scoreboard pops, stall stability, done pulse count.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (prev_stall) chk("out_stable", out_data, prev_data);
            if (out_ready) begin
                if (exp_q.size() == 0) chk("extra_output", exp_q.size(), 1);
                else chk("out_data", out_data, exp_q.pop_front());
            end
            prev_stall = !out_ready;
            prev_data  = out_data;
        end else begin
            prev_stall = 1'b0;
        end
        if (rst_n && done) done_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_seq(input int n, input int base);
        for (int i = 0; i < n*n; i++) mat_in[i] = 8'(base + i);
    endtask

    task automatic push_exp(input int n);
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                exp_q.push_back(mat_in[c*n + r]);
    endtask

    task automatic do_start(input logic [1:0] sz, output int e0);
        start = 1'b1;
        matrix_size = sz;
        step();
        e0 = cyc;
        start = 1'b0;
    endtask

    // Feed cnt elements; gaps inserts random idle cycles; inj raises start/size 11 at that element.
    task automatic feed(input int cnt, input bit gaps, input int inj);
        for (int i = 0; i < cnt; i++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                for (int k = 0; k < g; k++) begin
                    in_valid = 1'b0;
                    step();
                end
            end
            in_data  = mat_in[i];
            in_valid = 1'b1;
            if (i == inj) begin
                start = 1'b1;
                matrix_size = 2'b11;
            end
            for (int w = 0; w < 20 && !in_ready; w++) step();
            if (!in_ready) chk("in_ready_timeout", in_ready, 1);
            step();
            start    = 1'b0;
            in_valid = 1'b0;
        end
    endtask

    // Drain until the queue holds keep entries; toggle makes out_ready alternate 1/0.
    task automatic drain(input bit toggle, input int keep);
        int k;
        k = 0;
        while (exp_q.size() > keep && k < 400) begin
            out_ready = toggle ? ~k[0] : 1'b1;
            step();
            k++;
        end
        if (exp_q.size() > keep) chk("drain_timeout", exp_q.size(), keep);
        out_ready = 1'b0;
    endtask

    task automatic finish_run();
        chk("done_pulse", done, 1);
        chk("busy_in_done", busy, 1);
        step();
        chk("done_low", done, 0);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        int e0;

        // Reset state
        #2 rst_n = 1'b0;
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // 2x2, 1..4, no stalls: 1,3,2,4, done in cycle t0+10
        fill_seq(2, 1);
        push_exp(2);
        do_start(2'b00, e0);
        chk("busy_t0p1", busy, 1);
        chk("in_ready_load", in_ready, 1);
        feed(4, 1'b0, -1);
        chk("compute_no_ready", in_ready, 0);
        drain(1'b0, 0);
        chk("done_cycle_2x2", cyc - e0, 9);
        finish_run();

        // 3x3, 1..9, out_ready toggling
        fill_seq(3, 1);
        push_exp(3);
        do_start(2'b01, e0);
        feed(9, 1'b0, -1);
        drain(1'b1, 0);
        finish_run();

        // 5x5, 1..25, random in_valid gaps; result slot (r,c) = 5c+r+1
        fill_seq(5, 1);
        push_exp(5);
        do_start(2'b11, e0);
        feed(25, 1'b1, -1);
        drain(1'b0, 0);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                chk($sformatf("res5_r%0d_c%0d", r, c), dut.r_res[(r*5+c)*8 +: 8], 5*c + r + 1);
        finish_run();

        // 4x4 with start/size 11 mid-LOAD (ignored); padding slots stay 0
        fill_seq(4, 8'h31);
        push_exp(4);
        do_start(2'b10, e0);
        feed(16, 1'b0, 5);
        chk("4x4_load_end", in_ready, 0);
        chk("4x4_busy", busy, 1);
        drain(1'b0, 0);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("pad_row4_c%0d", i), dut.r_res[(4*5+i)*8 +: 8], 0);
            chk($sformatf("pad_col4_r%0d", i), dut.r_res[(i*5+4)*8 +: 8], 0);
        end
        finish_run();

        // Reset mid-DRAIN of a 3x3 after 4 outputs
        fill_seq(3, 8'h41);
        push_exp(3);
        do_start(2'b01, e0);
        feed(9, 1'b0, -1);
        drain(1'b0, 5);
        chk("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        step();
        fill_seq(2, 8'h21);
        push_exp(2);
        do_start(2'b00, e0);
        feed(4, 1'b0, -1);
        drain(1'b0, 0);
        finish_run();

        // Abort in LOAD after 2 elements, then 2x2 of 5..8 -> 5,7,6,8
        fill_seq(3, 8'h51);
        do_start(2'b01, e0);
        feed(2, 1'b0, -1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_no_done", done, 0);
        step();
        fill_seq(2, 5);
        push_exp(2);
        do_start(2'b00, e0);
        feed(4, 1'b0, -1);
        drain(1'b0, 0);
        finish_run();

        step();
        chk("done_pulse_count", done_cnt, 6);
        chk("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
